// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: owns HI/LO and runs MULT/MULTU/DIV/DIVU
// with a fixed latency. The result is computed at issue and committed when the countdown expires.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  // Two's-complement negate when requested; -0x80000000 wraps to itself.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
    return neg ? (~x + 32'd1) : x;
  endfunction

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             pvld_q, pvld_d;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_nz, a_mag, b_mag, quo_mag, rem_mag;
  logic [31:0]        quo_s, rem_s, quo_u, rem_u;

  assign a_sx   = $signed({{32{A[31]}}, A});
  assign b_sx   = $signed({{32{B[31]}}, B});
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divide on magnitudes and fix signs after, so MIN/-1 wraps instead of trapping.
  assign b_nz    = (B == 32'd0) ? 32'd1 : B;
  assign a_mag   = neg_if(A[31], A);
  assign b_mag   = neg_if(B[31], b_nz);
  assign quo_mag = a_mag / b_mag;
  assign rem_mag = a_mag % b_mag;
  assign quo_s   = neg_if(A[31] ^ B[31], quo_mag);
  assign rem_s   = neg_if(A[31], rem_mag);
  assign quo_u   = A / b_nz;
  assign rem_u   = A % b_nz;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    pvld_d = pvld_q;
    if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        if (pvld_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (Start) begin
      case (MDUOp)
        OP_MULT: begin
          {phi_d, plo_d} = prod_s;
          cnt_d  = MULT_CNT;
          busy_d = 1'b1;
          pvld_d = 1'b1;
        end
        OP_MULTU: begin
          {phi_d, plo_d} = prod_u;
          cnt_d  = MULT_CNT;
          busy_d = 1'b1;
          pvld_d = 1'b1;
        end
        OP_DIV: begin
          phi_d  = rem_s;
          plo_d  = quo_s;
          cnt_d  = DIV_CNT;
          busy_d = 1'b1;
          pvld_d = (B != 32'd0);
        end
        OP_DIVU: begin
          phi_d  = rem_u;
          plo_d  = quo_u;
          cnt_d  = DIV_CNT;
          busy_d = 1'b1;
          pvld_d = (B != 32'd0);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      pvld_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      pvld_q <= pvld_d;
    end
  end

  always_comb begin
    Out = '0;
    case (MDUOp)
      OP_MFHI: Out = hi_q;
      OP_MFLO: Out = lo_q;
      default: ;
    endcase
  end

  assign Busy = busy_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboarded bench for mdu: a reference model queues HI/LO/latency at issue,
// and the entries are popped and compared when Busy drops.
module tb_mdu;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] Out;

  mdu #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .MDUOp(MDUOp),
    .Start(Start),
    .Busy (Busy),
    .Out  (Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    MDUOp = 4'd7;
    #1 check({tag, "_hi"}, Out, ehi);
    MDUOp = 4'd8;
    #1 check({tag, "_lo"}, Out, elo);
    MDUOp = 4'd0;
    #1;
  endtask

  // Called at a negedge; drives one Start cycle and returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.cyc = (op <= 4'd2) ? MULT_CYC : DIV_CYC;
    case (op)
      4'd1: begin p = 64'(sa * sbv); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin
        q = sa / sbv;
        r = sa % sbv;
        p = 64'(q); m_lo = p[31:0];
        p = 64'(r); m_hi = p[31:0];
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
    MDUOp = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    if (op == 4'd5) m_hi = a; else m_lo = a;
    MDUOp = op; A = a; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
  endtask

  task automatic wait_done(input string tag, input int pre);
    int   n;
    exp_t e;
    n = pre;
    while (Busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_cyc"}, 32'(n), 32'(e.cyc));
      read_hilo(tag, e.hi, e.lo);
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_done("mult", 0);
    check("mult_hi_const", m_hi, 32'hFFFFFFFF);
    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    wait_done("multu", 0);
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg", 0);
    issue(4'd4, 32'd7, 32'd2);
    wait_done("divu", 0);

    mt(4'd5, 32'hAAAA0000);
    mt(4'd6, 32'h00005555);
    issue(4'd3, 32'd1234, 32'd0);
    wait_done("div_zero", 0);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 0);

    mt(4'd5, 32'h12345678);
    MDUOp = 4'd7;
    #1 check("mfhi", Out, 32'h12345678);
    mt(4'd6, 32'hDEADBEEF);
    MDUOp = 4'd8;
    #1 check("mflo", Out, 32'hDEADBEEF);
    MDUOp = 4'd0;
    #1 check("none_out", Out, 32'd0);

    // Back-to-back: next op issued in the first cycle with Busy low
    issue(4'd2, 32'd40000, 32'd50000);
    wait_done("b2b_a", 0);
    issue(4'd1, 32'hFFFF0000, 32'h00010000);
    wait_done("b2b_b", 0);

    issue(4'd1, 32'd2, 32'd3);
    check("ign_busy", {31'd0, Busy}, 32'd1);
    MDUOp = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(negedge clk);
    MDUOp = 4'd5; A = 32'hFFFFFFFF;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
    wait_done("ignore", 2);

    for (int i = 0; i < 6; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (b[0] && i == 3) b = ~b;
      issue(op, a, b);
      wait_done("rand", 0);
    end

    issue(4'd4, 32'd9, 32'd2);
    sb.delete(sb.size() - 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    MDUOp = 4'd5; A = 32'hFFFFFFFF; Start = 1'b1;
    @(negedge clk);
    reset = 1'b0; Start = 1'b0; MDUOp = 4'd0;
    m_hi = '0; m_lo = '0;
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    read_hilo("midrst", 32'd0, 32'd0);
    repeat (15) @(negedge clk);
    check("midrst_late_busy", {31'd0, Busy}, 32'd0);
    read_hilo("midrst_late", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It sits beside the ALU and takes the same forwarded rs/rt operands. It holds the architectural HI/LO registers and performs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency. Its Out result is muxed with the ALU's C into the EX/MEM register. Busy is consumed by the hazard unit, which stalls MDU instructions in ID.

## Interface
- MULT_CYCLES, 5: Busy cycles for MULT/MULTU.
- DIV_CYCLES, 10: Busy cycles for DIV/DIVU.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- A  in  32  forwarded rs operand.
- B  in  32  forwarded rt operand.
- MDUOp  in  4  operation code:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO
  - 9–15 treated as NONE.
- Start  in  1  EX-stage instruction valid (not a bubble). Qualifies the ops that change state: 1–6.
- Busy  out  1  high while a multiply/divide is in flight.
- Out  out  32  combinational read port:
  - MDUOp=7: HI
  - MDUOp=8: LO
  - otherwise 0.
  - Does not depend on Start.

## Operation
- State:
  - HI[31:0], LO[31:0]
  - pending result regs PHI[31:0], PLO[31:0]
  - down-counter cnt (width ≥ clog2(DIV_CYCLES+1))
  - Busy flag
  - pending-valid flag (cleared for divide-by-zero)
- Reset: HI=LO=0, PHI=PLO=0, cnt=0, Busy=0, Out follows HI/LO (0).
- Accept rule: an op with Start=1 is accepted only when Busy=0. With Busy=1, every Start is ignored, with no state change. The hazard unit must prevent this case; the block is still defined for it.
- Accepted MULT:
  - {PHI,PLO} = $signed(A)*$signed(B), full 64-bit result.
  - cnt=MULT_CYCLES, Busy=1.
- Accepted MULTU: same as MULT with an unsigned product.
- Accepted DIV:
  - PLO = signed quotient, truncated toward zero.
  - PHI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives PLO=0x80000000, PHI=0 (wraps).
  - cnt=DIV_CYCLES, Busy=1.
- Accepted DIVU: unsigned quotient/remainder, otherwise as DIV.
- Divide by zero (B=0, DIV or DIVU):
  - Busy still runs for DIV_CYCLES.
  - The pending-valid flag is cleared, so HI/LO are unchanged at completion.
- MTHI / MTLO (accepted): HI←A / LO←A at the edge. Busy is not affected.
- MFHI / MFLO: pure reads through Out, with no state change. A read during Busy returns the old HI/LO; the hazard unit is responsible for stalling it.
- Countdown: while Busy=1, cnt decrements each cycle. On the edge where cnt==1:
  - HI←PHI and LO←PLO (if pending-valid).
  - Busy←0, cnt←0.
- Results are computed at issue; the counter only models latency.

## Timing
- Issue at edge t (Start=1, Busy=0, op=MULT/MULTU):
  - Busy=1 during cycles t+1 … t+MULT_CYCLES.
  - HI/LO hold new values and Busy=0 from cycle t+MULT_CYCLES+1.
- DIV/DIVU: same pattern with DIV_CYCLES.
- Back-to-back issue: a new op is accepted in the first cycle Busy=0.
- MTHI/MTLO: new value visible on Out (MFHI/MFLO) in the cycle after the write edge. A same-cycle read returns the old value.
- Reset asserted in any cycle, including mid-operation:
  - The next cycle shows Busy=0, HI=LO=0, cnt=0.
  - The in-flight result is discarded.
  - Reset overrides a simultaneous Start.
- Stall condition exported to the hazard unit: (Start & MDUOp∈1..4) | Busy. The hazard unit combines these itself; the block outputs only Busy.

## Test plan
- MULT and MULTU, operands A=0xFFFFFFFE, B=3:
  - MULT: Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU on the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- DIV and DIVU:
  - DIV A=0xFFFFFFF9 (−7), B=2: Busy high exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2: LO=3, HI=1.
- Division edge cases:
  - Preload HI=0xAAAA0000, LO=0x5555 via MTHI/MTLO, then DIV with B=0: Busy runs 10 cycles, HI/LO unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Move-to / move-from:
  - MTHI A=0x12345678, then MFHI next cycle: Out=0x12345678.
  - MTLO A=0xDEADBEEF, then MFLO: Out=0xDEADBEEF.
  - MDUOp=0: Out=0.
- Start while Busy:
  - Issue MULT 2×3, then assert DIV 100/7 and MTHI 0xFFFFFFFF during Busy.
  - Both are ignored; after completion HI=0, LO=6.
- Reset mid-operation:
  - Issue DIVU 9/2 and assert reset on Busy cycle 3.
  - Next cycle: Busy=0, HI=LO=0; no later update occurs.
